// File: rtl/pkt_header_inserter.sv
// ---------------------------------------------------------------------------
// pkt_header_inserter
//
// Store-and-forward AXI-Stream header inserter. Each ingress packet is first
// captured whole into a local beat store while its byte count is accumulated.
// On egress a single header beat is emitted, carrying the byte count and the
// source identifier, and then the stored payload beats are replayed in order.
// Packets that do not fit in the store are discarded and counted.
//
// Ports
//   clk_i        : clock, all logic on the rising edge
//   rst_ni       : asynchronous active-low reset
//   s_tdata_i    : ingress data
//   s_tkeep_i    : ingress byte enables (contiguous from bit 0)
//   s_tvalid_i   : ingress beat valid
//   s_tlast_i    : ingress last beat of packet
//   s_tready_o   : ingress ready
//   m_tdata_o    : egress data (header beat, then payload)
//   m_tkeep_o    : egress byte enables
//   m_tvalid_o   : egress beat valid
//   m_tlast_o    : egress last beat
//   m_tready_i   : egress ready
//   drop_count_o : saturating count of dropped oversize packets
// ---------------------------------------------------------------------------
module pkt_header_inserter #(
  parameter int AXI_WIDTH    = 64,
  parameter int DEPTH_BEATS  = 256,
  parameter int INTERFACE_ID = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [AXI_WIDTH-1:0]   s_tdata_i,
  input  logic [AXI_WIDTH/8-1:0] s_tkeep_i,
  input  logic                   s_tvalid_i,
  input  logic                   s_tlast_i,
  output logic                   s_tready_o,
  output logic [AXI_WIDTH-1:0]   m_tdata_o,
  output logic [AXI_WIDTH/8-1:0] m_tkeep_o,
  output logic                   m_tvalid_o,
  output logic                   m_tlast_o,
  input  logic                   m_tready_i,
  output logic [15:0]            drop_count_o
);

  localparam int KEEP_W  = AXI_WIDTH / 8;
  localparam int ADDR_W  = (DEPTH_BEATS > 1) ? $clog2(DEPTH_BEATS) : 1;
  localparam int ENTRY_W = AXI_WIDTH + KEEP_W + 1;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH_BEATS);
  localparam logic [7:0]      ID_BYTE  = 8'(INTERFACE_ID);

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    DROP,
    HEADER,
    PAYLOAD
  } state_t;

  state_t r_state;
  state_t w_nextState;

  // Each store entry is {tlast, tkeep, tdata}.
  logic [ENTRY_W-1:0] r_store [DEPTH_BEATS];

  // The write pointer carries one extra bit so it doubles as the fill level.
  logic [ADDR_W:0]   r_wrPtr;
  logic [ADDR_W-1:0] r_rdPtr;
  logic [15:0]       r_byteCount;
  logic [15:0]       r_dropCount;
  logic              r_readyEn;

  logic              w_inHs;
  logic              w_outHs;
  logic              w_full;
  logic              w_storeBeat;
  logic              w_overflow;
  logic              w_dropDone;
  logic              w_payloadDone;
  logic [15:0]       w_beatBytes;
  logic [16:0]       w_byteSum;
  logic [ENTRY_W-1:0] w_rdEntry;
  logic [AXI_WIDTH-1:0] w_rdData;
  logic [KEEP_W-1:0] w_rdKeep;
  logic              w_rdLast;

  assign w_inHs      = s_tvalid_i & s_tready_o;
  assign w_outHs     = m_tvalid_o & m_tready_i;
  assign w_full      = (r_wrPtr == FULL_CNT);
  assign w_storeBeat = w_inHs & ((r_state == IDLE) | (r_state == CAPTURE)) & ~w_full;
  assign w_overflow  = w_inHs & (r_state == CAPTURE) & w_full;
  // A drop completes either on the tlast of an ongoing drop or when the
  // overflowing beat is itself the last one.
  assign w_dropDone  = (w_overflow & s_tlast_i) | (w_inHs & (r_state == DROP) & s_tlast_i);

  assign w_rdEntry     = r_store[r_rdPtr];
  assign w_rdData      = w_rdEntry[AXI_WIDTH-1:0];
  assign w_rdKeep      = w_rdEntry[AXI_WIDTH +: KEEP_W];
  assign w_rdLast      = w_rdEntry[ENTRY_W-1];
  assign w_payloadDone = w_outHs & (r_state == PAYLOAD) & w_rdLast;

  assign drop_count_o = r_dropCount;

  // Bytes carried by the current ingress beat, and the saturating running sum.
  always_comb begin
    w_beatBytes = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      w_beatBytes = w_beatBytes + 16'(s_tkeep_i[i]);
    end
  end

  assign w_byteSum = {1'b0, r_byteCount} + {1'b0, w_beatBytes};

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_inHs) begin
          w_nextState = s_tlast_i ? HEADER : CAPTURE;
        end
      end
      CAPTURE: begin
        if (w_inHs) begin
          if (w_full) begin
            w_nextState = s_tlast_i ? IDLE : DROP;
          end else if (s_tlast_i) begin
            w_nextState = HEADER;
          end
        end
      end
      DROP: begin
        if (w_inHs && s_tlast_i) begin
          w_nextState = IDLE;
        end
      end
      HEADER: begin
        if (w_outHs) begin
          w_nextState = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (w_outHs && w_rdLast) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Output logic. r_readyEn keeps ingress closed until the first edge after
  // reset is released.
  always_comb begin
    s_tready_o = 1'b0;
    m_tvalid_o = 1'b0;
    m_tdata_o  = '0;
    m_tkeep_o  = '0;
    m_tlast_o  = 1'b0;
    case (r_state)
      IDLE, CAPTURE, DROP: begin
        s_tready_o = r_readyEn;
      end
      HEADER: begin
        m_tvalid_o = 1'b1;
        m_tdata_o  = AXI_WIDTH'({ID_BYTE, r_byteCount});
        m_tkeep_o  = '1;
      end
      PAYLOAD: begin
        m_tvalid_o = 1'b1;
        m_tdata_o  = w_rdData;
        m_tkeep_o  = w_rdKeep;
        m_tlast_o  = w_rdLast;
      end
      default: begin
        s_tready_o = 1'b0;
      end
    endcase
  end

  // Pointers, byte counter and drop counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_readyEn   <= 1'b0;
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_byteCount <= '0;
      r_dropCount <= '0;
    end else begin
      r_readyEn <= 1'b1;
      if (w_storeBeat) begin
        r_wrPtr     <= r_wrPtr + (ADDR_W + 1)'(1);
        r_byteCount <= w_byteSum[16] ? 16'hFFFF : w_byteSum[15:0];
      end
      if (w_dropDone) begin
        r_wrPtr     <= '0;
        r_rdPtr     <= '0;
        r_byteCount <= '0;
        if (r_dropCount != 16'hFFFF) begin
          r_dropCount <= r_dropCount + 16'd1;
        end
      end
      if (w_outHs && (r_state == PAYLOAD)) begin
        r_rdPtr <= r_rdPtr + ADDR_W'(1);
      end
      if (w_payloadDone) begin
        r_wrPtr     <= '0;
        r_rdPtr     <= '0;
        r_byteCount <= '0;
      end
    end
  end

  // Beat store; contents need no reset since the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (w_storeBeat) begin
      r_store[r_wrPtr[ADDR_W-1:0]] <= {s_tlast_i, s_tkeep_i, s_tdata_i};
    end
  end

endmodule

// File: tb/tb_pkt_header_inserter.sv
// ---------------------------------------------------------------------------
// tb_pkt_header_inserter
//
// Directed and randomized bench for pkt_header_inserter with a small store
// (4 beats) and source identifier 5. Expected egress is derived from the
// packet contents: one header beat holding the total enabled-byte count and
// the identifier, followed by the packet beats unchanged; packets longer than
// the store produce no egress and bump the expected drop count.
// ---------------------------------------------------------------------------
module tb_pkt_header_inserter;

  localparam int         W     = 64;
  localparam int         KW    = W / 8;
  localparam int         DEPTH = 4;
  localparam logic [7:0] ID    = 8'd5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  s_tdata;
  logic [KW-1:0] s_tkeep;
  logic          s_tvalid;
  logic          s_tlast;
  logic          s_tready;
  logic [W-1:0]  m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tvalid;
  logic          m_tlast;
  logic          m_tready;
  logic [15:0]   drop_count;

  int checks = 0;
  int errors = 0;

  // Packet being offered on ingress.
  logic [W-1:0]  txData[$];
  logic [KW-1:0] txKeep[$];

  // Reference egress for the packet most recently modelled.
  logic [W-1:0]  expData[$];
  logic [KW-1:0] expKeep[$];
  logic          expLast[$];
  bit            expDropped;
  logic [15:0]   expDrops = '0;

  pkt_header_inserter #(
    .AXI_WIDTH   (W),
    .DEPTH_BEATS (DEPTH),
    .INTERFACE_ID(5)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .s_tdata_i   (s_tdata),
    .s_tkeep_i   (s_tkeep),
    .s_tvalid_i  (s_tvalid),
    .s_tlast_i   (s_tlast),
    .s_tready_o  (s_tready),
    .m_tdata_o   (m_tdata),
    .m_tkeep_o   (m_tkeep),
    .m_tvalid_o  (m_tvalid),
    .m_tlast_o   (m_tlast),
    .m_tready_i  (m_tready),
    .drop_count_o(drop_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [KW-1:0] keepOf(input int n);
    logic [15:0] m;
    m = (16'd1 << n) - 16'd1;
    return m[KW-1:0];
  endfunction

  task automatic genPacket(input int nBeats, input logic [KW-1:0] lastKeep);
    txData.delete();
    txKeep.delete();
    for (int i = 0; i < nBeats; i++) begin
      txData.push_back({$urandom, $urandom});
      txKeep.push_back((i == nBeats - 1) ? lastKeep : {KW{1'b1}});
    end
  endtask

  // Reference model: what egress must look like for the current packet.
  task automatic buildExpected;
    int bytes = 0;
    expData.delete();
    expKeep.delete();
    expLast.delete();
    if (txData.size() > DEPTH) begin
      expDropped = 1'b1;
      if (expDrops != 16'hFFFF) expDrops = expDrops + 16'd1;
    end else begin
      expDropped = 1'b0;
      foreach (txKeep[i]) bytes += $countones(txKeep[i]);
      if (bytes > 65535) bytes = 65535;
      expData.push_back({40'd0, ID, 16'(bytes)});
      expKeep.push_back({KW{1'b1}});
      expLast.push_back(1'b0);
      foreach (txData[i]) begin
        expData.push_back(txData[i]);
        expKeep.push_back(txKeep[i]);
        expLast.push_back(i == txData.size() - 1);
      end
    end
  endtask

  // Drive the first nSend beats of the current packet, optionally with gaps.
  // Entered and left at 1 time unit after a rising edge.
  task automatic applyStimulus(input int nSend, input bit gaps);
    for (int i = 0; i < nSend; i++) begin
      int waitCycles;
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_tvalid = 1'b0;
        @(posedge clk); #1;
      end
      s_tvalid = 1'b1;
      s_tdata  = txData[i];
      s_tkeep  = txKeep[i];
      s_tlast  = (i == txData.size() - 1);
      waitCycles = 0;
      while (s_tready !== 1'b1 && waitCycles < 100) begin
        @(posedge clk); #1;
        waitCycles++;
      end
      if (waitCycles >= 100) begin
        checkOutput("ingressTimeout", 64'(waitCycles), 64'd0);
        break;
      end
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic sendAndCheck(input bit gaps);
    applyStimulus(txData.size(), gaps);
    if (expDropped) begin
      checkOutput("dropCount", 64'(drop_count), 64'(expDrops));
      checkOutput("noHeaderOnDrop", 64'(m_tvalid), 64'd0);
    end else begin
      checkOutput("headerLatency", 64'(m_tvalid), 64'd1);
    end
  endtask

  // Collect egress and compare with the reference; optionally keep the next
  // packet's first beat offered to confirm ingress stays closed meanwhile.
  task automatic collectEgress(input bit randomReady, input bit offerNext);
    int            idx = 0;
    int            cyc = 0;
    bit            prevStall = 1'b0;
    logic [W-1:0]  pData = '0;
    logic [KW-1:0] pKeep = '0;
    logic          pLast = 1'b0;
    if (offerNext) begin
      s_tvalid = 1'b1;
      s_tdata  = txData[0];
      s_tkeep  = txKeep[0];
      s_tlast  = (txData.size() == 1);
    end
    while (idx < expData.size() && cyc < 500) begin
      m_tready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
      if (prevStall) begin
        checkOutput("stallData", m_tdata, pData);
        checkOutput("stallKeep", 64'(m_tkeep), 64'(pKeep));
        checkOutput("stallLast", 64'(m_tlast), 64'(pLast));
      end
      if (offerNext) checkOutput("ingressBlocked", 64'(s_tready), 64'd0);
      checkOutput("egressValid", 64'(m_tvalid), 64'd1);
      if (m_tready) begin
        checkOutput("egressData", m_tdata, expData[idx]);
        checkOutput("egressKeep", 64'(m_tkeep), 64'(expKeep[idx]));
        checkOutput("egressLast", 64'(m_tlast), 64'(expLast[idx]));
        idx++;
        prevStall = 1'b0;
      end else begin
        prevStall = 1'b1;
        pData = m_tdata;
        pKeep = m_tkeep;
        pLast = m_tlast;
      end
      @(posedge clk); #1;
      cyc++;
    end
    m_tready = 1'b1;
    checkOutput("egressBeats", 64'(idx), 64'(expData.size()));
    checkOutput("egressIdle", 64'(m_tvalid), 64'd0);
    if (offerNext) checkOutput("ingressReopened", 64'(s_tready), 64'd1);
  endtask

  task automatic checkResetOutputs;
    checkOutput("rstReady", 64'(s_tready), 64'd0);
    checkOutput("rstValid", 64'(m_tvalid), 64'd0);
    checkOutput("rstLast", 64'(m_tlast), 64'd0);
    checkOutput("rstData", m_tdata, 64'd0);
    checkOutput("rstKeep", 64'(m_tkeep), 64'd0);
    checkOutput("rstDrops", 64'(drop_count), 64'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;

    // Reset values and ready timing after release.
    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs();
    #2 rst_n = 1'b1;
    checkOutput("readyBeforeEdge", 64'(s_tready), 64'd0);
    @(posedge clk); #1;
    checkOutput("readyAfterEdge", 64'(s_tready), 64'd1);

    // Three beats, keep FF/FF/0F: 20 bytes.
    genPacket(3, 8'h0F);
    buildExpected();
    sendAndCheck(1'b0);
    collectEgress(1'b0, 1'b0);

    // Single beat, keep 01.
    genPacket(1, 8'h01);
    buildExpected();
    sendAndCheck(1'b0);
    collectEgress(1'b0, 1'b0);

    // Oversize packet dropped, followed by a normal one.
    genPacket(6, 8'hFF);
    buildExpected();
    sendAndCheck(1'b0);
    repeat (4) begin
      checkOutput("noEgressAfterDrop", 64'(m_tvalid), 64'd0);
      @(posedge clk); #1;
    end
    genPacket(2, keepOf(3));
    buildExpected();
    sendAndCheck(1'b0);
    collectEgress(1'b0, 1'b0);

    // Overflowing beat is itself the last one.
    genPacket(DEPTH + 1, 8'hFF);
    buildExpected();
    sendAndCheck(1'b0);

    // Exactly fills the store.
    genPacket(DEPTH, keepOf(7));
    buildExpected();
    sendAndCheck(1'b1);
    collectEgress(1'b0, 1'b0);

    // Empty last beat is still forwarded.
    genPacket(2, 8'h00);
    buildExpected();
    sendAndCheck(1'b0);
    collectEgress(1'b1, 1'b0);

    // Reset in the middle of a packet.
    genPacket(4, 8'hFF);
    applyStimulus(2, 1'b0);
    #2 rst_n = 1'b0;
    expDrops = '0;
    #1;
    checkResetOutputs();
    @(posedge clk);
    #2 rst_n = 1'b1;
    checkOutput("readyBeforeEdge2", 64'(s_tready), 64'd0);
    @(posedge clk); #1;
    checkOutput("readyAfterEdge2", 64'(s_tready), 64'd1);
    repeat (3) begin
      checkOutput("noHeaderAfterReset", 64'(m_tvalid), 64'd0);
      @(posedge clk); #1;
    end
    genPacket(3, keepOf(5));
    buildExpected();
    sendAndCheck(1'b0);
    collectEgress(1'b0, 1'b0);

    // Randomized packets with backpressure and the next packet offered early.
    genPacket($urandom_range(1, DEPTH + 2), keepOf($urandom_range(0, KW)));
    for (int k = 0; k < 30; k++) begin
      buildExpected();
      sendAndCheck(1'b1);
      genPacket($urandom_range(1, DEPTH + 2), keepOf($urandom_range(0, KW)));
      if (!expDropped) collectEgress(1'b1, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pkt_header_inserter.md
PKT_HEADER_INSERTER -- requirements
Module: pkt_header_inserter

Interface
REQ-001 SHALL have parameter AXI_WIDTH, default 64, data width in bits; legal values are multiples of 8.
REQ-002 SHALL have parameter DEPTH_BEATS, default 256, payload store capacity in beats; legal values are powers of 2.
REQ-003 SHALL have parameter INTERFACE_ID, default 0, 8-bit source identifier placed in the header.
REQ-004 SHALL use one clock and an asynchronous active-low reset, with ports listed below.
REQ-005 clk_i  input  1  clock, all logic rising-edge.
REQ-006 rst_ni  input  1  asynchronous active-low reset.
REQ-007 s_tdata_i  input  AXI_WIDTH  ingress packet data.
REQ-008 s_tkeep_i  input  AXI_WIDTH/8  ingress byte enables, contiguous from bit 0.
REQ-009 s_tvalid_i  input  1  ingress beat valid.
REQ-010 s_tlast_i  input  1  ingress last beat of packet.
REQ-011 s_tready_o  output  1  ingress ready.
REQ-012 m_tdata_o  output  AXI_WIDTH  egress data (header beat, then payload), feeds packet_buffer tdata_i.
REQ-013 m_tkeep_o  output  AXI_WIDTH/8  egress byte enables.
REQ-014 m_tvalid_o  output  1  egress beat valid.
REQ-015 m_tlast_o  output  1  egress last beat.
REQ-016 m_tready_i  input  1  egress ready.
REQ-017 drop_count_o  output  16  count of dropped oversize packets, saturating.

Function
REQ-018 SHALL be store-and-forward: the whole ingress packet is captured before any egress beat.
REQ-019 SHALL implement the states IDLE, CAPTURE, DROP, HEADER and PAYLOAD.
REQ-020 In IDLE and CAPTURE, s_tready_o SHALL be 1; in HEADER and PAYLOAD it SHALL be 0; in DROP it SHALL be 1.
REQ-021 A handshake occurs when valid and ready are both 1 on a rising edge; no other condition transfers data.
REQ-022 IDLE -> CAPTURE SHALL occur on the first ingress handshake without tlast; a single-beat packet (tlast on first beat) SHALL go IDLE -> HEADER.
REQ-023 Each accepted beat SHALL write {tdata, tkeep, tlast} to the store at the write pointer; the write pointer then increments.
REQ-024 The byte counter SHALL accumulate popcount(tkeep) per accepted beat; width 16 bits, saturating at 0xFFFF.
REQ-025 CAPTURE -> HEADER SHALL occur on the tlast handshake.
REQ-026 A beat accepted while the store already holds DEPTH_BEATS beats SHALL move the FSM to DROP; that beat is not stored.
REQ-027 DROP SHALL discard beats until the tlast handshake, then go to IDLE with pointers cleared and drop_count_o incremented (saturating at 0xFFFF).
REQ-028 If the overflowing beat itself carries tlast, the FSM SHALL go directly to IDLE with the drop counted.
REQ-029 In HEADER, m_tvalid_o SHALL be 1 starting the cycle after the ingress tlast handshake (1-cycle latency).
REQ-030 The header beat SHALL have the following fields: m_tdata_o[15:0] = byte count, [23:16] = INTERFACE_ID, all other bits 0; m_tkeep_o all ones; m_tlast_o 0.
REQ-031 HEADER -> PAYLOAD SHALL occur on the header handshake.
REQ-032 PAYLOAD SHALL present stored beats in order with the read pointer advancing per handshake, back-to-back with no bubbles while m_tready_i = 1.
REQ-033 In PAYLOAD, m_tkeep_o and m_tlast_o SHALL equal the stored values.
REQ-034 On the last-beat handshake, the FSM SHALL go to IDLE, clear pointers and clear the byte counter; the next ingress beat may be accepted the following cycle.
REQ-035 Egress outputs SHALL be held stable while m_tvalid_o = 1 and m_tready_i = 0.
REQ-036 A tlast beat with tkeep = 0 SHALL be stored and forwarded, contributing 0 bytes to the count.

Reset
REQ-037 Assertion of rst_ni SHALL immediately force the FSM to IDLE and set s_tready_o = 0, m_tvalid_o = 0, m_tlast_o = 0, m_tdata_o = 0, m_tkeep_o = 0, drop_count_o = 0, with pointers and byte counter cleared.
REQ-038 While rst_ni = 0, s_tready_o SHALL be 0; after deassertion, IDLE SHALL raise s_tready_o on the first rising edge.
REQ-039 Reset mid-packet SHALL abandon the partial packet; no header beat is emitted for it.

Verification
REQ-040 Scenario 3-beat packet, tkeep FF,FF,0F, m_tready_i = 1 -> header data 0x000014 (20 bytes, ID 0) one cycle after tlast, then 3 payload beats back-to-back, tlast on the third.
REQ-041 Scenario single beat, tkeep 01, INTERFACE_ID = 5 -> header [15:0] = 1, [23:16] = 5, then one payload beat with tlast = 1 and tkeep = 01.
REQ-042 Scenario DEPTH_BEATS = 4, 6-beat packet -> no egress, drop_count_o = 1; the following 2-beat packet is forwarded correctly.
REQ-043 Scenario m_tready_i toggling randomly at 50% -> payload matches ingress bytewise and outputs are stable during stalls.
REQ-044 Scenario rst_ni pulsed low after 2 beats of a 4-beat packet -> all outputs at reset values; a fresh packet afterwards yields a correct header.
REQ-045 Scenario ingress beats offered during HEADER/PAYLOAD -> s_tready_o = 0 and no beat is lost once IDLE is reached.
